// File: rtl/pkt_strip_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pkt_strip_pkg
// Purpose : Shared widths, limits and state encoding for the pkt_strip
//           checksum-stripping datapath.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package pkt_strip_pkg;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 12;
  localparam int CNT_W  = 16;

  // Largest reportable payload length; longer payloads saturate here.
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pkt_stat_cnt.sv
`default_nettype none
// ============================================================================
// Module  : pkt_stat_cnt
// Purpose : Wrapping statistics counter that can step by 0, 1 or 2 per cycle.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset (clears the count)
//           inc   - increment amount for this cycle (0/1/2)
//           cnt   - current count, wraps from all-ones to zero
// Revision: 1.0 - initial release
// ============================================================================
module pkt_stat_cnt
  import pkt_strip_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(inc);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pkt_strip.sv
`default_nettype none
// ============================================================================
// Module  : pkt_strip
// Purpose : Removes the trailing checksum word from each packet. Every word
//           is held for one cycle so that the word preceding eop can itself
//           be flagged as the last payload word. Packets without a proper
//           eop are closed with an error flag; checksum-only packets and
//           stray words are dropped.
// Ports   : clk, rst_n                - clock, async active-low reset
//           din, din_vld/sop/eop      - input packet stream (no backpressure)
//           dout, dout_vld/sop/eop    - payload stream, checksum removed
//           dout_err                  - abort flag, valid with dout_eop
//           dout_len                  - payload length, valid with dout_eop
//           pkt_cnt                   - good packets emitted (wraps)
//           runt_cnt                  - dropped/aborted packets (wraps)
// Revision: 1.0 - initial release
// ============================================================================
module pkt_strip
  import pkt_strip_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  input  logic              din_sop,
  input  logic              din_eop,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic              dout_err,
  output logic [LEN_W-1:0]  dout_len,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  runt_cnt
);

  state_t            state;
  logic [DATA_W-1:0] hold_data;
  logic              hold_sop;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_next;
  logic [1:0]        pkt_inc;
  logic [1:0]        runt_inc;

  assign len_next = (len == LEN_MAX) ? len : len + 1'b1;

  // Counter steps are decoded from the word being sampled so the counters
  // update on the same edge that registers the corresponding output word.
  always_comb begin
    pkt_inc  = 2'd0;
    runt_inc = 2'd0;
    if (din_vld) begin
      case (state)
        IDLE: begin
          if (din_sop && din_eop) begin
            runt_inc = 2'd1;
          end
        end
        IN_PKT: begin
          if (din_sop) begin
            // Aborted packet, plus a checksum-only packet on the same word.
            runt_inc = din_eop ? 2'd2 : 2'd1;
          end else if (din_eop) begin
            pkt_inc = 2'd1;
          end
        end
        default: begin
          pkt_inc  = 2'd0;
          runt_inc = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_data <= '0;
      hold_sop  <= 1'b0;
      len       <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      dout_sop  <= 1'b0;
      dout_eop  <= 1'b0;
      dout_err  <= 1'b0;
      dout_len  <= '0;
    end else begin
      // Outputs are zero unless a word is emitted this cycle.
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      dout_err <= 1'b0;
      dout_len <= '0;

      case (state)
        IDLE: begin
          if (din_vld && din_sop && !din_eop) begin
            hold_data <= din;
            hold_sop  <= 1'b1;
            len       <= LEN_W'(1);
            state     <= IN_PKT;
          end
        end

        IN_PKT: begin
          if (din_vld) begin
            dout     <= hold_data;
            dout_vld <= 1'b1;
            dout_sop <= hold_sop;
            if (din_sop) begin
              // Missing eop: close the held packet as aborted, then treat
              // din as the start of a new packet.
              dout_eop <= 1'b1;
              dout_err <= 1'b1;
              dout_len <= len;
              if (din_eop) begin
                state <= IDLE;
              end else begin
                hold_data <= din;
                hold_sop  <= 1'b1;
                len       <= LEN_W'(1);
              end
            end else if (din_eop) begin
              // din is the checksum; the held word is the last payload word.
              dout_eop <= 1'b1;
              dout_len <= len;
              state    <= IDLE;
            end else begin
              hold_data <= din;
              hold_sop  <= 1'b0;
              len       <= len_next;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  pkt_stat_cnt u_pkt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pkt_inc),
    .cnt   (pkt_cnt)
  );

  pkt_stat_cnt u_runt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (runt_inc),
    .cnt   (runt_cnt)
  );

endmodule
`default_nettype wire

// File: doc/pkt_strip.md
PKT_STRIP -- requirements
Module: pkt_strip

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock for all logic.
REQ-002 SHALL have rst_n, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have din, input, 16, packet word from the upstream drop-on-error FIFO.
REQ-004 SHALL have din_vld, din_sop, din_eop, input, 1 each, word valid / first word / last word; din_sop and din_eop are only meaningful when din_vld=1.
REQ-005 SHALL have dout, output, 16, payload word with the trailing checksum word removed.
REQ-006 SHALL have dout_vld, dout_sop, dout_eop, output, 1 each, payload valid / first / last.
REQ-007 SHALL have dout_err, output, 1, asserted with dout_eop when a packet was closed by a missing-eop abort.
REQ-008 SHALL have dout_len, output, 12, payload word count; valid only when dout_vld=1 and dout_eop=1, otherwise 0.
REQ-009 SHALL have pkt_cnt, output, 16, count of good packets emitted; wraps at 65535->0.
REQ-010 SHALL have runt_cnt, output, 16, count of packets dropped or closed abnormally; wraps.
REQ-011 SHALL provide no backpressure: one word per cycle is accepted whenever din_vld=1.

Function
REQ-012 SHALL keep a one-word hold register (data, sop flag) plus a 12-bit length counter len.
REQ-013 SHALL use states IDLE and IN_PKT.
REQ-014 IDLE, vld&sop&!eop: load hold (sop flag=1), len=1, go to IN_PKT, no output.
REQ-015 IDLE, vld&sop&eop (1-word packet, checksum only): drop, runt_cnt+1, stay IDLE, no output.
REQ-016 IDLE, vld&!sop: discard the stray word, no output, no counter change.
REQ-017 IN_PKT, vld&!sop&!eop: emit the hold word (vld=1, sop=hold sop flag, eop=0), load din into hold with sop flag=0, len+1.
REQ-018 IN_PKT, vld&!sop&eop: emit the hold word with eop=1, err=0, dout_len=len, then discard din (checksum), pkt_cnt+1, go to IDLE.
REQ-019 IN_PKT, vld&sop (missing eop): emit the hold word with eop=1, err=1, dout_len=len, runt_cnt+1, then treat din as in REQ-014 or REQ-015.
REQ-019a When REQ-019 is followed by REQ-015, the block SHALL increment runt_cnt by 2 in that cycle and return to IDLE.
REQ-020 IN_PKT, !vld: hold state, no output; gaps of any length SHALL be tolerated.
REQ-021 All outputs SHALL be registered.
REQ-021a Word N of a packet SHALL appear on dout in the cycle after word N+1 is sampled.
REQ-021b dout_vld SHALL be a single-cycle pulse per emitted word.
REQ-022 When dout_vld=0, dout, dout_sop, dout_eop, dout_err and dout_len SHALL be 0.
REQ-023 len SHALL saturate at 4095; payloads longer than 4095 words report 4095.
REQ-024 A 2-word packet (payload + checksum) SHALL emit one word with sop=1, eop=1, len=1.

Reset
REQ-025 On rst_n=0, all outputs, counters, len and hold SHALL be 0, and state SHALL be IDLE, asynchronously.
REQ-026 A packet in progress at reset SHALL be discarded without output.
REQ-026a After reset, the first accepted word SHALL be the next word with din_sop=1.

Structure
REQ-027 Package pkt_strip_pkg SHALL hold the state enum (IDLE, IN_PKT), DATA_W=16, LEN_W=12 and CNT_W=16.
REQ-028 One sub-module, pkt_stat_cnt, SHALL implement a wrapping CNT_W counter with a 2-bit increment input (0/1/2).
REQ-028a pkt_stat_cnt SHALL be instantiated twice: for pkt_cnt and for runt_cnt.

Verification
REQ-029 Stimulus: 4 back-to-back words A1,A2,A3,CK (sop on A1, eop on CK). Response: A1(sop),A2,A3(eop, len=3) on consecutive cycles starting one cycle after A2; pkt_cnt=1.
REQ-030 Stimulus: 3-word packet with 2-cycle gaps between words. Response: 2 output pulses with matching gaps; the last pulse has eop=1, len=2.
REQ-031 Stimulus: 1-word packet (sop&eop), then a 2-word packet 0x1234,CK. Response: runt_cnt=1; one output 0x1234 with sop=eop=1, len=1.
REQ-032 Stimulus: sop B1, B2, then sop C1 (no eop), C2, CK(eop). Response: B1(sop), B2(eop, err=1, len=2); C1(sop), C2(eop, len=2); runt_cnt=1, pkt_cnt=1.
REQ-033 Stimulus: stray words without sop in IDLE, then rst_n pulsed mid-packet. Response: no output; all outputs and counters 0 during and after reset; the next packet is processed normally.
REQ-034 Stimulus: 4100-word payload. Response: 4100 output pulses; len=4095 on eop.
